// File: rtl/range_counter_pkg.sv
// Shared encodings for the range counter: step mode and count direction.
package range_counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/range_counter_next.sv
// Combinational next-count and terminal-count decode for range_counter.
module range_counter_next
    import range_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] count_q_i,
    input  logic             en_i,
    input  logic             up_dn_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic             oor_i,
    input  logic             cfg_err_i,
    output logic [WIDTH-1:0] count_d_o,
    output logic             tc_d_o
);

    logic sat;
    logic up;

    assign sat = (mode_i == MODE_SAT);
    assign up  = (up_dn_i == DIR_UP);

    always_comb begin
        count_d_o = count_q_i;
        tc_d_o    = 1'b0;
        if (load_i) begin
            count_d_o = data_i;
        end else if (en_i && !cfg_err_i) begin
            // Bounds are tested before +/-1, so the arithmetic never wraps mod 2^WIDTH.
            if (oor_i) begin
                count_d_o = up ? lo_i : hi_i;
            end else if (up) begin
                if (count_q_i == hi_i) begin
                    tc_d_o    = 1'b1;
                    count_d_o = sat ? hi_i : lo_i;
                end else begin
                    count_d_o = count_q_i + 1'b1;
                end
            end else begin
                if (count_q_i == lo_i) begin
                    tc_d_o    = 1'b1;
                    count_d_o = sat ? lo_i : hi_i;
                end else begin
                    count_d_o = count_q_i - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/range_counter.sv
// Up/down counter bounded by runtime [lo,hi] with wrap or saturate at the bounds.
module range_counter
    import range_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned RST_VAL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             oor,
    output logic             cfg_err
);

    localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;

    assign oor     = (count_q < lo) || (count_q > hi);
    assign cfg_err = (lo > hi);
    assign count   = count_q;
    assign tc      = tc_q;

    range_counter_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .count_q_i (count_q),
        .en_i      (en),
        .up_dn_i   (up_dn),
        .mode_i    (mode),
        .load_i    (load),
        .data_i    (data),
        .lo_i      (lo),
        .hi_i      (hi),
        .oor_i     (oor),
        .cfg_err_i (cfg_err),
        .count_d_o (count_d),
        .tc_d_o    (tc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_COUNT;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

endmodule
